// File: rtl/seg_led_dynamic_avl.sv
// seg_led_dynamic_avl: Avalon-MM slave driving a multiplexed common-anode
// seven-segment display of DIG_NUM digits (active-low sel and segments).
// Optional feature macro: SEG_BLINK_EN adds the per-digit BLINK register at
// word address 4 plus the blink phase generator (parameter BLINK_TICKS).
//
// Bus handshake: fixed-latency Avalon-MM slave with no waitrequest. A write
// is accepted on the clock edge where avl_write=1. avl_readdata is loaded on
// the edge where avl_read=1 and is valid from then on. It holds until the
// next read. A same-cycle read and write to one address returns the old
// value.
module seg_led_dynamic_avl #(
  parameter int DIG_NUM   = 6,
  parameter int CLK_FREQ  = 50_000_000,
`ifdef SEG_BLINK_EN
  parameter int BLINK_TICKS = 250,
`endif
  parameter int SCAN_FREQ = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         avl_address,
  input  logic               avl_write,
  input  logic [31:0]        avl_writedata,
  input  logic               avl_read,
  output logic [31:0]        avl_readdata,
  output logic [DIG_NUM-1:0] sel,
  output logic [7:0]         seg_led
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int DW       = 4 * DIG_NUM;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIG_NUM - 1);
  localparam logic [DIG_NUM-1:0] SEL_ONE  = DIG_NUM'(1);

  logic [DW-1:0]      data_r;
  logic [1:0]         ctrl_r;      // [0]=EN, [1]=LZB
  logic [DIG_NUM-1:0] dp_r;
  logic [DIG_NUM-1:0] blank_r;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               scan_tick;
  logic [3:0]         nibble;
  logic               lz_zero;
  logic               digit_dark;
  logic               blink_dark;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  // Upper write-data bits are don't-care for narrow fields.
  assign unused_wdata = ^avl_writedata;

  // Hex to active-low gfedcba, same table as the static display driver.
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
    endcase
  endfunction

  // Register file writes; reserved addresses and excess bits are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      ctrl_r  <= '0;
      dp_r    <= '0;
      blank_r <= '0;
    end else if (avl_write) begin
      case (avl_address)
        3'd0:    data_r  <= avl_writedata[DW-1:0];
        3'd1:    ctrl_r  <= avl_writedata[1:0];
        3'd2:    dp_r    <= avl_writedata[DIG_NUM-1:0];
        3'd3:    blank_r <= avl_writedata[DIG_NUM-1:0];
        default: ;
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  logic [DIG_NUM-1:0] blink_r;
  logic [BLK_W-1:0]   blk_cnt;
  logic               blink_phase;

  // BLINK mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              blink_r <= '0;
    else if (avl_write && avl_address == 3'd4) blink_r <= avl_writedata[DIG_NUM-1:0];
  end

  // Blink half-period counter in scan ticks; phase 0 is the lit phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (scan_tick) begin
      if (blk_cnt == BLK_LAST) begin
        blk_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  assign blink_dark = blink_phase & blink_r[idx];
`else
  assign blink_dark = 1'b0;
`endif

  // Read data mux; unused bits and reserved addresses read zero.
  always_comb begin
    rd_mux = '0;
    case (avl_address)
      3'd0: rd_mux[DW-1:0]      = data_r;
      3'd1: rd_mux[1:0]         = ctrl_r;
      3'd2: rd_mux[DIG_NUM-1:0] = dp_r;
      3'd3: rd_mux[DIG_NUM-1:0] = blank_r;
`ifdef SEG_BLINK_EN
      3'd4: rd_mux[DIG_NUM-1:0] = blink_r;
`endif
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        avl_readdata <= '0;
    else if (avl_read) avl_readdata <= rd_mux;
  end

  assign scan_tick = (cnt == CNT_LAST);

  // Free-running scan divider, independent of EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (scan_tick) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  // Digit index advances once per scan tick and wraps at DIG_NUM-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  idx <= '0;
    else if (scan_tick) begin
      if (idx == IDX_LAST)       idx <= '0;
      else                       idx <= idx + 1'b1;
    end
  end

  assign nibble = data_r[{idx, 2'b00} +: 4];

  // Darkness: explicit blank, leading-zero blanking (never digit 0), blink.
  always_comb begin
    lz_zero = 1'b1;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (i >= int'(idx) && data_r[4*i +: 4] != 4'h0) lz_zero = 1'b0;
    end
    digit_dark = blank_r[idx] | (ctrl_r[1] & (idx != '0) & lz_zero) | blink_dark;
  end

  // Registered pin drive; dp follows DP regardless of darkness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= '1;
      seg_led <= 8'hFF;
    end else if (!ctrl_r[0]) begin
      sel     <= '1;
      seg_led <= 8'hFF;
    end else begin
      sel     <= ~(SEL_ONE << idx);
      seg_led <= {~dp_r[idx], digit_dark ? 7'h7F : enc(nibble)};
    end
  end

endmodule

// File: tb/tb_seg_led_dynamic_avl.sv
// Bench for seg_led_dynamic_avl: DIG_NUM=6, CLK_FREQ=100, SCAN_FREQ=10.
// Define SEG_BLINK_EN on both files to cover the blink build.
module tb_seg_led_dynamic_avl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avl_address = '0;
  logic        avl_write = 1'b0;
  logic [31:0] avl_writedata = '0;
  logic        avl_read = 1'b0;
  logic [31:0] avl_readdata;
  logic [5:0]  sel;
  logic [7:0]  seg_led;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ctrl;
    logic [5:0]  dp;
    logic [5:0]  blank;
    int          dig;
    logic [7:0]  seg;
  } vec_t;
  vec_t vt[$];

  seg_led_dynamic_avl #(
    .DIG_NUM(6),
    .CLK_FREQ(100),
`ifdef SEG_BLINK_EN
    .BLINK_TICKS(2),
`endif
    .SCAN_FREQ(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avl_address(avl_address), .avl_write(avl_write), .avl_writedata(avl_writedata),
    .avl_read(avl_read), .avl_readdata(avl_readdata),
    .sel(sel), .seg_led(seg_led)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avl_address = a; avl_writedata = d; avl_write = 1'b1;
    @(posedge clk); #1;
    avl_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [2:0] a, input string name);
    logic [31:0] e;
    @(posedge clk); #1;
    avl_address = a; avl_read = 1'b1;
    @(posedge clk); #1;
    avl_read = 1'b0;
    e = exp_q.pop_front();
    check(name, avl_readdata, e);
  endtask

  // Waits for the start of digit d's slot; ok=0 on timeout.
  task automatic wait_digit(input int d, output bit ok);
    logic [5:0] want;
    int n;
    want = ~(6'd1 << d);
    n = 0;
    @(negedge clk);
    while (sel == want && n < 100) begin @(negedge clk); n++; end
    while (sel != want && n < 100) begin @(negedge clk); n++; end
    ok = (sel == want);
  endtask

  initial begin
    bit ok;
    int n;
    int errs;
    logic [7:0] v [4];

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sel", {26'd0, sel}, 32'h3F);
    check("rst_seg", {24'd0, seg_led}, 32'hFF);
    check("rst_rd", avl_readdata, 32'h0);

    // Release reset together with a CTRL=1 write; check output latency and divider.
    @(posedge clk); #1;
    rst_n = 1'b1;
    avl_address = 3'd1; avl_writedata = 32'h1; avl_write = 1'b1;
    @(posedge clk); #1;
    avl_write = 1'b0;
    check("en_lag_sel", {26'd0, sel}, 32'h3F);
    @(posedge clk); #1;
    check("en_first_sel", {26'd0, sel}, 32'h3E);
    n = 2;
    while (sel == 6'h3E && n < 40) begin @(posedge clk); #1; n++; end
    check("first_advance_cycle", n, 11);
    check("first_advance_sel", {26'd0, sel}, 32'h3D);

    // Vector table: register setup, digit to observe, expected segments.
    vt.push_back('{32'h00543210, 2'd1, 6'h00, 6'h00, 0, 8'hC0});
    vt.push_back('{32'h00543210, 2'd1, 6'h00, 6'h00, 1, 8'hF9});
    vt.push_back('{32'h00543210, 2'd1, 6'h00, 6'h00, 2, 8'hA4});
    vt.push_back('{32'h00543210, 2'd1, 6'h00, 6'h00, 3, 8'hB0});
    vt.push_back('{32'h00543210, 2'd1, 6'h00, 6'h00, 4, 8'h99});
    vt.push_back('{32'h00543210, 2'd1, 6'h00, 6'h00, 5, 8'h92});
    vt.push_back('{32'h00543210, 2'd1, 6'h01, 6'h02, 0, 8'h40});
    vt.push_back('{32'h00543210, 2'd1, 6'h01, 6'h02, 1, 8'hFF});
    vt.push_back('{32'h00000000, 2'd3, 6'h00, 6'h00, 0, 8'hC0});
    vt.push_back('{32'h00000000, 2'd3, 6'h00, 6'h00, 1, 8'hFF});
    vt.push_back('{32'h00000000, 2'd3, 6'h00, 6'h00, 3, 8'hFF});
    vt.push_back('{32'h00000000, 2'd3, 6'h00, 6'h00, 5, 8'hFF});
    vt.push_back('{32'h00000100, 2'd3, 6'h00, 6'h00, 2, 8'hF9});
    vt.push_back('{32'h00000100, 2'd3, 6'h00, 6'h00, 1, 8'hC0});
    vt.push_back('{32'h00000100, 2'd3, 6'h00, 6'h00, 0, 8'hC0});
    vt.push_back('{32'h00000100, 2'd3, 6'h00, 6'h00, 3, 8'hFF});
    vt.push_back('{32'h00000100, 2'd3, 6'h00, 6'h00, 5, 8'hFF});
    vt.push_back('{32'h00FEDCBA, 2'd1, 6'h00, 6'h00, 0, 8'h88});
    vt.push_back('{32'h00FEDCBA, 2'd1, 6'h00, 6'h00, 1, 8'h83});
    vt.push_back('{32'h00FEDCBA, 2'd1, 6'h00, 6'h00, 2, 8'hC6});
    vt.push_back('{32'h00FEDCBA, 2'd1, 6'h00, 6'h00, 3, 8'hA1});
    vt.push_back('{32'h00FEDCBA, 2'd1, 6'h00, 6'h00, 4, 8'h86});
    vt.push_back('{32'h00FEDCBA, 2'd1, 6'h00, 6'h00, 5, 8'h8E});
    vt.push_back('{32'h00987654, 2'd1, 6'h00, 6'h00, 0, 8'h99});
    vt.push_back('{32'h00987654, 2'd1, 6'h00, 6'h00, 2, 8'h82});
    vt.push_back('{32'h00987654, 2'd1, 6'h00, 6'h00, 3, 8'hF8});
    vt.push_back('{32'h00987654, 2'd1, 6'h00, 6'h00, 4, 8'h80});
    vt.push_back('{32'h00987654, 2'd1, 6'h00, 6'h00, 5, 8'h90});
    vt.push_back('{32'h00000005, 2'd3, 6'h20, 6'h00, 5, 8'h7F});
    vt.push_back('{32'h00000005, 2'd3, 6'h20, 6'h00, 0, 8'h92});
    vt.push_back('{32'h00000005, 2'd3, 6'h20, 6'h00, 1, 8'hFF});
    vt.push_back('{32'h00000000, 2'd1, 6'h01, 6'h01, 0, 8'h7F});
    vt.push_back('{32'h00000000, 2'd1, 6'h01, 6'h01, 1, 8'hC0});

    foreach (vt[i]) begin
      bus_write(3'd0, vt[i].data);
      bus_write(3'd1, {30'd0, vt[i].ctrl});
      bus_write(3'd2, {26'd0, vt[i].dp});
      bus_write(3'd3, {26'd0, vt[i].blank});
      wait_digit(vt[i].dig, ok);
      check($sformatf("vec%0d_found", i), {31'd0, ok}, 32'h1);
      check($sformatf("vec%0d_seg", i), {24'd0, seg_led}, {24'd0, vt[i].seg});
    end

    // Slot length and scan order including wrap 5 -> 0.
    bus_write(3'd2, 32'h0);
    bus_write(3'd3, 32'h0);
    for (int d = 0; d < 6; d++) begin
      wait_digit(d, ok);
      n = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (sel != ~(6'd1 << d)) break;
        n++;
      end
      check($sformatf("slot%0d_len", d), n, 10);
      check($sformatf("slot%0d_next", d), {26'd0, sel}, {26'd0, ~(6'd1 << ((d + 1) % 6))});
    end

    // EN=0 keeps everything dark.
    bus_write(3'd1, 32'h2);
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (sel !== 6'h3F || seg_led !== 8'hFF) errs++;
    end
    check("en0_dark_cycles", errs, 0);

    // Readback through the expected queue.
    bus_write(3'd0, 32'hFFFFFFFF);
    exp_q.push_back(32'h00FFFFFF); bus_read(3'd0, "rd_data");
    repeat (3) @(posedge clk); #1;
    check("rd_hold", avl_readdata, 32'h00FFFFFF);
    bus_write(3'd2, 32'hFFFFFFFF);
    exp_q.push_back(32'h3F); bus_read(3'd2, "rd_dp");
    bus_write(3'd3, 32'hFFFFFFFF);
    exp_q.push_back(32'h3F); bus_read(3'd3, "rd_blank");
    bus_write(3'd1, 32'hFFFFFFFF);
    exp_q.push_back(32'h3); bus_read(3'd1, "rd_ctrl");
    bus_write(3'd5, 32'h0);
    bus_write(3'd7, 32'h0);
    exp_q.push_back(32'h0); bus_read(3'd5, "rd_addr5");
    exp_q.push_back(32'h0); bus_read(3'd6, "rd_addr6");
    exp_q.push_back(32'h0); bus_read(3'd7, "rd_addr7");
    exp_q.push_back(32'h00FFFFFF); bus_read(3'd0, "rd_data_kept");
    bus_write(3'd4, 32'hFFFFFFFF);
`ifdef SEG_BLINK_EN
    exp_q.push_back(32'h3F); bus_read(3'd4, "rd_blink");
`else
    exp_q.push_back(32'h0); bus_read(3'd4, "rd_addr4");
`endif
    bus_write(3'd4, 32'h0);

    // Same-cycle read and write of CTRL returns the old value.
    bus_write(3'd1, 32'h1);
    @(posedge clk); #1;
    avl_address = 3'd1; avl_writedata = 32'h0; avl_write = 1'b1; avl_read = 1'b1;
    @(posedge clk); #1;
    avl_write = 1'b0; avl_read = 1'b0;
    check("rd_wr_same_cycle", avl_readdata, 32'h1);
    exp_q.push_back(32'h0); bus_read(3'd1, "rd_ctrl_after");

`ifdef SEG_BLINK_EN
    // Blink: digit 0 alternates lit/dark on successive visits, digit 1 steady.
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd1, 32'h1);
    bus_write(3'd4, 32'h1);
    for (int k = 0; k < 4; k++) begin
      wait_digit(0, ok);
      v[k] = seg_led;
      check($sformatf("blink%0d_valid", k), {31'd0, (v[k] == 8'hC0 || v[k] == 8'hFF)}, 32'h1);
      if (k > 0) check($sformatf("blink%0d_toggle", k), {31'd0, (v[k] != v[k-1])}, 32'h1);
    end
    wait_digit(1, ok);
    check("blink_other_digit", {24'd0, seg_led}, 32'hC0);
    bus_write(3'd4, 32'h0);
`endif

    // Asynchronous reset mid-scan, then restart from idx 0 and cnt 0.
    bus_write(3'd0, 32'h00123456);
    bus_write(3'd1, 32'h1);
    exp_q.push_back(32'h00123456); bus_read(3'd0, "rd_before_rst");
    wait_digit(3, ok);
    check("rst_mid_found", {31'd0, ok}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel", {26'd0, sel}, 32'h3F);
    check("rst_mid_seg", {24'd0, seg_led}, 32'hFF);
    check("rst_mid_rd", avl_readdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(32'h0); bus_read(3'd1, "rst_ctrl_cleared");
    exp_q.push_back(32'h0); bus_read(3'd0, "rst_data_cleared");
    bus_write(3'd1, 32'h1);
    check("rst_restart_sel", {26'd0, sel}, 32'h3E);
    n = 7;
    while (sel == 6'h3E && n < 40) begin @(posedge clk); #1; n++; end
    check("rst_restart_advance", n, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
